// File: rtl/key_matrix_scan_if.sv
// Keypad pin and key-report bundle for key_matrix_scan.
//   key_col   : column lines from the keypad, pulled up, 0 = contact closed
//   key_row   : one-hot active-low row drive
//   key_value : {row_idx, col_idx} of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_hold  : high while the accepted key stays pressed
// master = scanner side, slave = keypad/consumer side.
interface key_matrix_scan_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_hold;

  modport master (
    input  key_col,
    output key_row,
    output key_value,
    output key_valid,
    output key_hold
  );

  modport slave (
    output key_col,
    input  key_row,
    input  key_value,
    input  key_valid,
    input  key_hold
  );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Strobes one row at a time, reads the synchronized columns and reports one
// code per physical press (key_valid pulse) plus a hold level.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad pins and key report (see key_matrix_scan_if)
// TIME_SCAN = row dwell - 1, TIME_DEB = debounce window - 1, in clk cycles.
module key_matrix_scan #(
  parameter int unsigned TIME_SCAN = 49_999,
  parameter int unsigned TIME_DEB  = 999_999
) (
  input  logic               clk,
  input  logic               rst_n,
  key_matrix_scan_if.master  kp
);

  localparam int unsigned CNT_MAX = (TIME_DEB > TIME_SCAN) ? TIME_DEB : TIME_SCAN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(TIME_SCAN);
  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(TIME_DEB);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       col_m, col_s;
  logic [3:0]       row, row_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [3:0]       col_ref, col_ref_nxt;
  logic [3:0]       value, value_nxt;
  logic             valid, valid_nxt;
  logic             hold, hold_nxt;
  logic [1:0]       cur_row_idx;
  logic [1:0]       first_low;
  logic [3:0]       row_rot;

  assign kp.key_row   = row;
  assign kp.key_value = value;
  assign kp.key_valid = valid;
  assign kp.key_hold  = hold;

  assign row_rot = {row[2:0], row[3]};

  // Position of the driven (low) row bit.
  always_comb begin
    cur_row_idx = 2'd0;
    case (row)
      4'b1101: cur_row_idx = 2'd1;
      4'b1011: cur_row_idx = 2'd2;
      4'b0111: cur_row_idx = 2'd3;
      default: cur_row_idx = 2'd0;
    endcase
  end

  // Lowest closed column wins when several are low.
  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) first_low = 2'(i);
    end
  end

  // Column synchronizer; idles at all-open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= kp.key_col;
      col_s <= col_m;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      cnt     <= '0;
      row     <= 4'b1110;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      col_ref <= 4'hF;
      value   <= 4'h0;
      valid   <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      row     <= row_nxt;
      row_idx <= row_idx_nxt;
      col_idx <= col_idx_nxt;
      col_ref <= col_ref_nxt;
      value   <= value_nxt;
      valid   <= valid_nxt;
      hold    <= hold_nxt;
    end
  end

  // Next-state and next-output logic; cnt restarts on every state change.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    row_nxt     = row;
    row_idx_nxt = row_idx;
    col_idx_nxt = col_idx;
    col_ref_nxt = col_ref;
    value_nxt   = value;
    valid_nxt   = 1'b0;
    hold_nxt    = hold;

    case (state)
      SCAN: begin
        if (cnt == SCAN_END) begin
          cnt_nxt = '0;
          if (col_s == 4'hF) begin
            row_nxt = row_rot;
          end else begin
            row_idx_nxt = cur_row_idx;
            col_idx_nxt = first_low;
            col_ref_nxt = col_s;
            state_nxt   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != col_ref) begin
          cnt_nxt   = '0;
          row_nxt   = row_rot;
          state_nxt = SCAN;
        end else if (cnt == DEB_END) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
          value_nxt = {row_idx, col_idx};
          valid_nxt = 1'b1;
          hold_nxt  = 1'b1;
        end
      end
      HOLD: begin
        // Only the accepted column matters; other keys are ignored.
        cnt_nxt = '0;
        if (col_s[col_idx]) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!col_s[col_idx]) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else if (cnt == DEB_END) begin
          cnt_nxt   = '0;
          row_nxt   = row_rot;
          hold_nxt  = 1'b0;
          state_nxt = SCAN;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = SCAN;
      end
    endcase
  end

endmodule
